// File: rtl/chien_pos_collector.sv
// Collects Chien-search root positions into an ordered error-position list for Forney.
// Latency: hits on a beat are in the list the next cycle; done_i moves to HOLD, list_valid_o the cycle after.
// Backpressure: the list is held stable in HOLD until list_ready_i; start_i is refused unless idle.
module chien_pos_collector #(
  parameter int W = 10,
  parameter int T = 11,
  parameter int P = 32,
  parameter int n = 544
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [3:0]     sigma_deg_i,
  output logic           start_ready_o,
  input  logic [P-1:0]   hit_mask_i,
  input  logic [P*W-1:0] pos_bus_i,
  input  logic           done_i,
  output logic           list_valid_o,
  input  logic           list_ready_i,
  output logic [T*W-1:0] err_pos_o,
  output logic [3:0]     err_cnt_o,
  output logic           fail_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  // Positions at or beyond the codeword length are shortening padding.
  localparam logic [W:0] N_LIM = (W+1)'(n);
  localparam logic [4:0] T_LIM = 5'(T);

  state_t       state, state_n;
  logic [W-1:0] list_q [T];
  logic [W-1:0] list_n [T];
  logic [4:0]   cnt_q, cnt_n;
  logic         ovf_q, ovf_n;
  logic [3:0]   deg_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: one search per start, hold the result until downstream takes it.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_i)      state_n = COLLECT;
      COLLECT: if (done_i)       state_n = HOLD;
      HOLD:    if (list_ready_i) state_n = IDLE;
      default:                   state_n = IDLE;
    endcase
  end

  // Append this beat's qualified hits in lane order; anything past T entries only flags overflow.
  always_comb begin
    list_n = list_q;
    cnt_n  = cnt_q;
    ovf_n  = ovf_q;
    for (int i = 0; i < P; i++) begin
      if (hit_mask_i[i] && ({1'b0, pos_bus_i[i*W +: W]} < N_LIM)) begin
        if (cnt_n < T_LIM) begin
          for (int k = 0; k < T; k++) begin
            if (5'(k) == cnt_n) begin
              list_n[k] = pos_bus_i[i*W +: W];
            end
          end
          cnt_n = cnt_n + 5'd1;
        end else begin
          ovf_n = 1'b1;
        end
      end
    end
  end

  // List storage: cleared on accepted start, updated only while collecting, frozen otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      deg_q <= '0;
      for (int k = 0; k < T; k++) begin
        list_q[k] <= '0;
      end
    end else if (state == IDLE && start_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      deg_q <= sigma_deg_i;
      for (int k = 0; k < T; k++) begin
        list_q[k] <= '0;
      end
    end else if (state == COLLECT) begin
      cnt_q  <= cnt_n;
      ovf_q  <= ovf_n;
      list_q <= list_n;
    end
  end

  // Pack the list onto the output bus, entry 0 in the low bits.
  always_comb begin
    err_pos_o = '0;
    for (int k = 0; k < T; k++) begin
      err_pos_o[k*W +: W] = list_q[k];
    end
  end

  assign start_ready_o = (state == IDLE);
  assign list_valid_o  = (state == HOLD);
  assign err_cnt_o     = cnt_q[3:0];
  // A locator whose root count disagrees with its degree, or that cannot fit, is uncorrectable.
  assign fail_o        = list_valid_o &
                         (ovf_q | (cnt_q != {1'b0, deg_q}) | ({1'b0, deg_q} > T_LIM));

endmodule

// File: tb/tb_chien_pos_collector.sv
module tb_chien_pos_collector;
  localparam int W = 10;
  localparam int T = 11;
  localparam int P = 32;
  localparam int N = 544;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [3:0]     sigma_deg;
  logic           start_ready;
  logic [P-1:0]   hit_mask;
  logic [P*W-1:0] pos_bus;
  logic           done;
  logic           list_valid;
  logic           list_ready;
  logic [T*W-1:0] err_pos;
  logic [3:0]     err_cnt;
  logic           fail;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chien_pos_collector #(.W(W), .T(T), .P(P), .n(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .sigma_deg_i  (sigma_deg),
    .start_ready_o(start_ready),
    .hit_mask_i   (hit_mask),
    .pos_bus_i    (pos_bus),
    .done_i       (done),
    .list_valid_o (list_valid),
    .list_ready_i (list_ready),
    .err_pos_o    (err_pos),
    .err_cnt_o    (err_cnt),
    .fail_o       (fail)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: a searching/holding flag pair plus a queue of accepted positions.
  int mq[$];
  bit m_ovf  = 0;
  bit m_coll = 0;
  bit m_hold = 0;
  int m_deg  = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf  = 0;
      m_coll = 0;
      m_hold = 0;
    end else if (m_hold) begin
      if (list_ready) m_hold = 0;
    end else if (m_coll) begin
      for (int l = 0; l < P; l++) begin
        int p;
        p = int'(pos_bus[l*W +: W]);
        if (hit_mask[l] && p < N) begin
          if (mq.size() < T) mq.push_back(p);
          else m_ovf = 1;
        end
      end
      if (done) begin
        m_coll = 0;
        m_hold = 1;
      end
    end else if (start) begin
      mq.delete();
      m_ovf  = 0;
      m_deg  = int'(sigma_deg);
      m_coll = 1;
    end
  end

  // Per-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("start_ready", int'(start_ready), int'(!(m_coll || m_hold)));
      check("list_valid", int'(list_valid), int'(m_hold));
      if (m_hold) begin
        check("err_cnt", int'(err_cnt), mq.size());
        check("fail", int'(fail), int'(m_ovf || mq.size() != m_deg || m_deg > T));
        for (int k = 0; k < T; k++) begin
          check("err_pos", int'(err_pos[k*W +: W]), (k < mq.size()) ? mq[k] : 0);
        end
      end else begin
        check("fail_not_valid", int'(fail), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bus();
    hit_mask = '0;
    pos_bus  = '0;
  endtask

  task automatic put(input int lane, input int p);
    hit_mask[lane] = 1'b1;
    pos_bus[lane*W +: W] = W'(p);
  endtask

  task automatic rand_bus(input int thr);
    clr_bus();
    for (int l = 0; l < P; l++) begin
      if ($urandom_range(0, thr) == 0) put(l, int'($urandom_range(0, 700)));
    end
  endtask

  task automatic do_start(input int d);
    start     = 1'b1;
    sigma_deg = 4'(d);
    tick();
    start     = 1'b0;
    clr_bus();
  endtask

  task automatic send(input bit last);
    done = last;
    tick();
    done = 1'b0;
    clr_bus();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 8 && !list_valid; i++) tick();
    check("wait_list_valid", int'(list_valid), 1);
  endtask

  task automatic accept();
    list_ready = 1'b1;
    tick();
    list_ready = 1'b0;
  endtask

  function automatic int pos_at(input int k);
    return int'(err_pos[k*W +: W]);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; start = 1'b0; sigma_deg = '0; done = 1'b0; list_ready = 1'b0;
    clr_bus();
    tick();
    tick();
    chk_en = 1;
    check("rst_valid", int'(list_valid), 0);
    check("rst_cnt", int'(err_cnt), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_ready", int'(start_ready), 1);
    for (int k = 0; k < T; k++) check("rst_pos", pos_at(k), 0);
    rst = 1'b0;
    tick();

    // Two beats, list in arrival then lane order.
    do_start(3);
    put(5, 100); send(0);
    put(2, 40); put(9, 31); send(1);
    wait_valid();
    check("d1_cnt", int'(err_cnt), 3);
    check("d1_fail", int'(fail), 0);
    check("d1_p0", pos_at(0), 100);
    check("d1_p1", pos_at(1), 40);
    check("d1_p2", pos_at(2), 31);
    check("d1_p3", pos_at(3), 0);
    accept();
    check("d1_idle", int'(start_ready), 1);

    // Twelve hits for an eleven-deep list.
    do_start(11);
    for (int l = 0; l < 12; l++) put(l, 200 + l);
    send(1);
    wait_valid();
    check("d2_cnt", int'(err_cnt), 11);
    check("d2_fail", int'(fail), 1);
    check("d2_p0", pos_at(0), 200);
    check("d2_p10", pos_at(10), 210);
    accept();

    // Padding position is ignored.
    do_start(1);
    put(3, 600); put(4, 7); send(1);
    wait_valid();
    check("d3_cnt", int'(err_cnt), 1);
    check("d3_fail", int'(fail), 0);
    check("d3_p0", pos_at(0), 7);
    check("d3_p1", pos_at(1), 0);
    accept();

    // Fewer roots than the degree.
    do_start(4);
    put(0, 1); put(1, 2); put(2, 3); send(1);
    wait_valid();
    check("d4_cnt", int'(err_cnt), 3);
    check("d4_fail", int'(fail), 1);
    accept();

    // Stalled downstream with a start pulse in the middle.
    do_start(2);
    put(6, 55); put(7, 66); send(1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; sigma_deg = 4'd5; end
      tick();
      start = 1'b0;
      check("d5_valid", int'(list_valid), 1);
      check("d5_ready", int'(start_ready), 0);
      check("d5_cnt", int'(err_cnt), 2);
      check("d5_p0", pos_at(0), 55);
      check("d5_p1", pos_at(1), 66);
      check("d5_fail", int'(fail), 0);
    end
    accept();
    check("d5_after_valid", int'(list_valid), 0);
    check("d5_after_ready", int'(start_ready), 1);
    check("d5_after_fail", int'(fail), 0);

    // Reset during collection, then a fresh codeword.
    do_start(2);
    put(1, 11); put(2, 22); send(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d6_valid", int'(list_valid), 0);
    check("d6_ready", int'(start_ready), 1);
    tick();
    check("d6_valid2", int'(list_valid), 0);
    do_start(1);
    put(0, 9); send(1);
    wait_valid();
    check("d6_cnt", int'(err_cnt), 1);
    check("d6_fail", int'(fail), 0);
    check("d6_p0", pos_at(0), 9);
    accept();

    // Degree zero, no roots.
    do_start(0);
    send(1);
    wait_valid();
    check("d7_cnt", int'(err_cnt), 0);
    check("d7_fail", int'(fail), 0);
    accept();

    // Randomized codewords with junk traffic outside the search window.
    for (int c = 0; c < 60; c++) begin
      int nb;
      int thr;
      nb  = int'($urandom_range(1, 5));
      thr = int'($urandom_range(2, 12));
      repeat ($urandom_range(0, 2)) begin
        rand_bus(thr);
        done = 1'($urandom_range(0, 1));
        tick();
        done = 1'b0;
        clr_bus();
      end
      do_start(int'($urandom_range(0, 13)));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin start = 1'b1; sigma_deg = 4'($urandom); end
        rand_bus(thr);
        send(b == nb - 1);
        start = 1'b0;
      end
      wait_valid();
      repeat ($urandom_range(0, 3)) begin
        rand_bus(thr);
        start = 1'($urandom_range(0, 1));
        done  = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        done  = 1'b0;
        clr_bus();
      end
      accept();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
